// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI bus arbiter: FSM states, bus owner
// encoding and counter widths.
package spi_pkg;

  localparam int PHASE_W = 8;
  localparam int WD_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_GAP    = 3'd4
  } arb_state_t;

  typedef enum logic {
    OWN_SEND = 1'b0,
    OWN_READ = 1'b1
  } owner_t;

  // A grant is held (and CS low) from SETUP through HOLD.
  function automatic logic owns_bus(input arb_state_t st);
    return (st == ST_SETUP) || (st == ST_ACTIVE) || (st == ST_HOLD);
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_if.sv
// Request/done handshake and grant/chip-select bus between the send and read
// engines (slave side) and the arbiter (master side).
interface spi_bus_arbiter_if;
  logic send_req;
  logic read_req;
  logic send_done;
  logic read_done;
  logic mutex;
  logic omutex;
  logic spi_cs;
  logic start;
  logic busy;
  logic timeout;

  modport master (
    input  send_req, read_req, send_done, read_done,
    output mutex, omutex, spi_cs, start, busy, timeout
  );

  modport slave (
    output send_req, read_req, send_done, read_done,
    input  mutex, omutex, spi_cs, start, busy, timeout
  );
endinterface

// File: rtl/spi_arb_rr.sv
// Two-way round-robin grant select: on a tie the requester not granted last wins.
module spi_arb_rr
  import spi_pkg::*;
(
  input  logic   send_req,
  input  logic   read_req,
  input  owner_t last_owner,
  output logic   grant_valid,
  output owner_t grant_owner
);

  // Pick the winner for this cycle's request pattern.
  always_comb begin
    grant_valid = 1'b0;
    grant_owner = OWN_SEND;
    case ({send_req, read_req})
      2'b10: begin
        grant_valid = 1'b1;
        grant_owner = OWN_SEND;
      end
      2'b01: begin
        grant_valid = 1'b1;
        grant_owner = OWN_READ;
      end
      2'b11: begin
        grant_valid = 1'b1;
        grant_owner = (last_owner == OWN_SEND) ? OWN_READ : OWN_SEND;
      end
      default: begin
        grant_valid = 1'b0;
        grant_owner = OWN_SEND;
      end
    endcase
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Arbitrates the shared SPI bus between a send and a read engine and sequences
// chip select. Optional watchdog in ACTIVE enabled by macro SPI_ARB_TIMEOUT_EN.
module spi_bus_arbiter
  import spi_pkg::*;
#(
  parameter int CS_SETUP       = 2,
  parameter int CS_HOLD        = 2,
  parameter int IDLE_GAP       = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  spi_bus_arbiter_if.master  bus
);

  localparam logic [PHASE_W-1:0] SETUP_LAST = PHASE_W'(CS_SETUP - 1);
  localparam logic [PHASE_W-1:0] HOLD_LAST  = PHASE_W'(CS_HOLD - 1);
  localparam logic [PHASE_W-1:0] GAP_LAST   = PHASE_W'(IDLE_GAP - 1);

  arb_state_t         state_r, next_s;
  logic [PHASE_W-1:0] phase_cnt_r;
  owner_t             owner_r, last_owner_r, next_owner_s, grant_owner_s;
  logic               grant_valid_s, owner_done_s, bus_phase_s;
  logic               mutex_r, omutex_r, spi_cs_r, start_r, busy_r;

  spi_arb_rr u_rr (
    .send_req    (bus.send_req),
    .read_req    (bus.read_req),
    .last_owner  (last_owner_r),
    .grant_valid (grant_valid_s),
    .grant_owner (grant_owner_s)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt_r;
  logic            timeout_r;
  logic            wd_expire_s;
  assign wd_expire_s = (state_r == ST_ACTIVE) && !owner_done_s && (wd_cnt_r == WD_LAST);
`endif

  // Next-state decode; only the current owner's done ends ACTIVE.
  always_comb begin
    next_s       = state_r;
    owner_done_s = (owner_r == OWN_SEND) ? bus.send_done : bus.read_done;
    case (state_r)
      ST_IDLE: begin
        if (grant_valid_s) next_s = ST_SETUP;
        else               next_s = ST_IDLE;
      end
      ST_SETUP: begin
        if (phase_cnt_r == SETUP_LAST) next_s = ST_ACTIVE;
        else                           next_s = ST_SETUP;
      end
      ST_ACTIVE: begin
        if (owner_done_s) next_s = ST_HOLD;
`ifdef SPI_ARB_TIMEOUT_EN
        else if (wd_expire_s) next_s = ST_HOLD;
`endif
        else next_s = ST_ACTIVE;
      end
      ST_HOLD: begin
        if (phase_cnt_r == HOLD_LAST) next_s = ST_GAP;
        else                          next_s = ST_HOLD;
      end
      ST_GAP: begin
        if (phase_cnt_r == GAP_LAST) next_s = ST_IDLE;
        else                         next_s = ST_GAP;
      end
      default: next_s = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    bus_phase_s = owns_bus(next_s);
    if ((state_r == ST_IDLE) && grant_valid_s) next_owner_s = grant_owner_s;
    else                                       next_owner_s = owner_r;
  end

  // State, phase counter, owner/pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      phase_cnt_r  <= 8'd0;
      owner_r      <= OWN_SEND;
      last_owner_r <= OWN_READ;
      mutex_r      <= 1'b0;
      omutex_r     <= 1'b0;
      spi_cs_r     <= 1'b1;
      start_r      <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r <= next_s;
      if ((next_s != state_r) || (next_s == ST_IDLE) || (next_s == ST_ACTIVE))
        phase_cnt_r <= 8'd0;
      else
        phase_cnt_r <= phase_cnt_r + 8'd1;
      if ((state_r == ST_IDLE) && grant_valid_s) begin
        owner_r      <= grant_owner_s;
        last_owner_r <= grant_owner_s;
      end
      mutex_r  <= bus_phase_s && (next_owner_s == OWN_SEND);
      omutex_r <= bus_phase_s && (next_owner_s == OWN_READ);
      spi_cs_r <= !bus_phase_s;
      start_r  <= (state_r == ST_SETUP) && (next_s == ST_ACTIVE);
      busy_r   <= (next_s != ST_IDLE);
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  // Watchdog counts ACTIVE cycles; timeout flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_r  <= 16'd0;
      timeout_r <= 1'b0;
    end else begin
      if ((state_r == ST_ACTIVE) && (next_s == ST_ACTIVE)) wd_cnt_r <= wd_cnt_r + 16'd1;
      else                                                  wd_cnt_r <= 16'd0;
      if (wd_expire_s) timeout_r <= 1'b1;
    end
  end
  assign bus.timeout = timeout_r;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.mutex  = mutex_r;
  assign bus.omutex = omutex_r;
  assign bus.spi_cs = spi_cs_r;
  assign bus.start  = start_r;
  assign bus.busy   = busy_r;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed self-checking bench for spi_bus_arbiter (default timing parameters,
// watchdog limit 16 when SPI_ARB_TIMEOUT_EN is defined).
module tb_spi_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;
  int   excl_viol = 0;
  bit   seen;

  spi_bus_arbiter_if bus();

  spi_bus_arbiter #(
    .CS_SETUP(2), .CS_HOLD(2), .IDLE_GAP(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Grants must never overlap.
  always @(negedge clk) begin
    if (bus.mutex && bus.omutex) excl_viol++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.send_req = 1'b0; bus.read_req = 1'b0;
    bus.send_done = 1'b0; bus.read_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_start(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (bus.start) found = 1'b1;
    end
  endtask

  task automatic wait_idle(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (!bus.busy) found = 1'b1;
    end
  endtask

  // One transaction: owner checked at start, done returned in the start cycle.
  task automatic run_txn(input string tag, input bit exp_send);
    bit ok;
    wait_start(40, ok);
    check_val({tag, "_start"}, 32'(ok), 32'd1);
    check_val({tag, "_mutex"}, 32'(bus.mutex), 32'(exp_send));
    check_val({tag, "_omutex"}, 32'(bus.omutex), 32'(!exp_send));
    if (exp_send) bus.send_done = 1'b1;
    else          bus.read_done = 1'b1;
    tick();
    bus.send_done = 1'b0; bus.read_done = 1'b0;
    check_val({tag, "_hold_cs"}, 32'(bus.spi_cs), 32'd0);
    wait_idle(40, ok);
    check_val({tag, "_idle"}, 32'(ok), 32'd1);
  endtask

  initial begin
    do_reset();
    rst = 1'b1;
    tick();
    check_val("rst_mutex",   32'(bus.mutex),   32'd0);
    check_val("rst_omutex",  32'(bus.omutex),  32'd0);
    check_val("rst_cs",      32'(bus.spi_cs),  32'd1);
    check_val("rst_start",   32'(bus.start),   32'd0);
    check_val("rst_busy",    32'(bus.busy),    32'd0);
    check_val("rst_timeout", 32'(bus.timeout), 32'd0);
    rst = 1'b0;
    tick(); tick();
    check_val("idle_no_req_busy", 32'(bus.busy), 32'd0);

    // Single send transaction with a stray read_done during ACTIVE.
    do_reset();
    bus.send_req = 1'b1;
    for (int t = 1; t <= 18; t++) begin
      tick();
      case (t)
        1: begin
          check_val("t1_mutex",  32'(bus.mutex),  32'd1);
          check_val("t1_omutex", 32'(bus.omutex), 32'd0);
          check_val("t1_cs",     32'(bus.spi_cs), 32'd0);
          check_val("t1_busy",   32'(bus.busy),   32'd1);
          check_val("t1_start",  32'(bus.start),  32'd0);
          bus.send_req = 1'b0;
        end
        2: check_val("t2_start", 32'(bus.start), 32'd0);
        3: check_val("t3_start", 32'(bus.start), 32'd1);
        4: check_val("t4_start", 32'(bus.start), 32'd0);
        5: bus.read_done = 1'b1;
        6: bus.read_done = 1'b0;
        8: begin
          check_val("t8_cs_after_foreign_done", 32'(bus.spi_cs), 32'd0);
          check_val("t8_mutex", 32'(bus.mutex), 32'd1);
        end
        10: begin
          check_val("t10_cs", 32'(bus.spi_cs), 32'd0);
          bus.send_done = 1'b1;
        end
        11: begin
          bus.send_done = 1'b0;
          check_val("t11_cs", 32'(bus.spi_cs), 32'd0);
        end
        12: check_val("t12_cs", 32'(bus.spi_cs), 32'd0);
        13: begin
          check_val("t13_cs",    32'(bus.spi_cs), 32'd1);
          check_val("t13_mutex", 32'(bus.mutex),  32'd0);
          check_val("t13_busy",  32'(bus.busy),   32'd1);
        end
        16: check_val("t16_busy", 32'(bus.busy), 32'd1);
        17: check_val("t17_busy", 32'(bus.busy), 32'd0);
        18: check_val("t18_busy", 32'(bus.busy), 32'd0);
        default: ;
      endcase
    end

    // Both requests held: grants alternate send, read, send.
    do_reset();
    bus.send_req = 1'b1; bus.read_req = 1'b1;
    run_txn("rr1_send", 1'b1);
    run_txn("rr2_read", 1'b0);
    run_txn("rr3_send", 1'b1);
    bus.send_req = 1'b0; bus.read_req = 1'b0;

    // Reset in ACTIVE releases everything on the next edge.
    do_reset();
    bus.read_req = 1'b1;
    wait_start(20, seen);
    check_val("rstact_start", 32'(seen), 32'd1);
    check_val("rstact_omutex_pre", 32'(bus.omutex), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check_val("rstact_cs",     32'(bus.spi_cs), 32'd1);
    check_val("rstact_mutex",  32'(bus.mutex),  32'd0);
    check_val("rstact_omutex", 32'(bus.omutex), 32'd0);
    check_val("rstact_busy",   32'(bus.busy),   32'd0);
    rst = 1'b0;
    bus.read_req = 1'b0;

`ifdef SPI_ARB_TIMEOUT_EN
    // Watchdog: 16 ACTIVE cycles without done forces HOLD and sets timeout.
    do_reset();
    bus.send_req = 1'b1;
    wait_start(20, seen);
    check_val("wd_start", 32'(seen), 32'd1);
    bus.send_req = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check_val("wd_a16_timeout", 32'(bus.timeout), 32'd0);
    check_val("wd_a16_cs",      32'(bus.spi_cs),  32'd0);
    tick();
    check_val("wd_hold1_timeout", 32'(bus.timeout), 32'd1);
    check_val("wd_hold1_cs",      32'(bus.spi_cs),  32'd0);
    tick();
    check_val("wd_hold2_cs", 32'(bus.spi_cs), 32'd0);
    tick();
    check_val("wd_gap_cs", 32'(bus.spi_cs), 32'd1);
    for (int i = 0; i < 10; i++) tick();
    check_val("wd_sticky",    32'(bus.timeout), 32'd1);
    check_val("wd_idle_busy", 32'(bus.busy),    32'd0);
    rst = 1'b1;
    tick();
    check_val("wd_rst_clear", 32'(bus.timeout), 32'd0);
    rst = 1'b0;
`else
    // Without the watchdog ACTIVE waits indefinitely.
    do_reset();
    bus.send_req = 1'b1;
    wait_start(20, seen);
    check_val("nowd_start", 32'(seen), 32'd1);
    bus.send_req = 1'b0;
    begin
      int cs_high_cnt = 0;
      for (int i = 0; i < 5000; i++) begin
        tick();
        if (bus.spi_cs || !bus.mutex || bus.timeout) cs_high_cnt++;
      end
      check_val("nowd_bad_cycles", 32'(cs_high_cnt), 32'd0);
    end
    check_val("nowd_busy",    32'(bus.busy),    32'd1);
    check_val("nowd_timeout", 32'(bus.timeout), 32'd0);
`endif

    check_val("mutex_exclusive", 32'(excl_viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
